// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the IMEM loader: FSM state encoding, err_code
// values, parameter defaults and the per-state output flag decode.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int DEPTH_DEFAULT = 1024;
    localparam int AW_DEFAULT    = 10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } loader_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    // Status outputs that are a pure function of the state being entered.
    // They are registered alongside the state so they never glitch.
    typedef struct packed {
        logic rx_ready;
        logic busy;
        logic done;
        logic error;
        logic core_reset;
    } state_flags_t;

    function automatic state_flags_t flags_of(input loader_state_t s);
        state_flags_t f;
        f = '0;
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
                f.rx_ready = 1'b1;
                f.busy     = 1'b1;
            end
            S_DONE: begin
                f.done       = 1'b1;
                f.core_reset = 1'b1;
            end
            S_ERR:   f.error = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects payload bytes little-endian into 32-bit words. The first byte of
// a word ends up in bits [7:0], the fourth in bits [31:24].
//
// Ports:
//   CLK        clock
//   reset      asynchronous active-low reset
//   clear      restart assembly at lane 0 (new load)
//   byte_en    byte_in is accepted this cycle
//   byte_in    payload byte
//   word_next  word including byte_in, valid when word_done is high
//   word_done  byte_en on the fourth lane of a word
// ---------------------------------------------------------------------------
module word_assembler (
    input  logic        CLK,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_done
);

    logic [1:0]  lane;
    logic [31:0] shreg;

    // Shifting right means byte 0 migrates down to [7:0] after four bytes,
    // so a gap in byte_en simply pauses assembly without losing position.
    assign word_next = {byte_in, shreg[31:8]};
    assign word_done = byte_en && (lane == 2'd3);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            lane  <= 2'd0;
            shreg <= 32'd0;
        end else if (clear) begin
            lane  <= 2'd0;
            shreg <= 32'd0;
        end else if (byte_en) begin
            lane  <= lane + 2'd1;
            shreg <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a program image over a byte stream and writes it into IMEM while
// holding the core in reset. Stream: LEN_LO, LEN_HI (word count N,
// little-endian), 4N payload bytes, then one XOR checksum byte.
//
// Ports:
//   CLK, reset        clock, asynchronous active-low reset
//   start             one-cycle load request (ignored while busy)
//   rx_data/rx_valid  incoming byte stream
//   rx_ready          loader accepts a byte this cycle
//   imem_we/addr/wdata one-cycle IMEM word write
//   core_reset        active-low core reset, released only in DONE
//   busy/done/error   load progress and outcome
//   err_code          00 none, 01 bad length, 10 checksum mismatch
//   state             current FSM state (debug visibility)
//
// Handshake: a byte transfers on a rising edge where rx_valid and rx_ready
// are both 1. rx_ready does not depend on rx_valid; rx_valid while rx_ready
// is low is ignored, and the source may drop rx_valid between any bytes.
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output loader_state_t state
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_flags_t flags;
    logic [15:0]  len;
    logic [15:0]  word_cnt;
    logic [7:0]   csum;

    logic         accept;
    logic         can_start;
    logic [16:0]  len_full;
    logic         len_bad;
    logic         word_done;
    logic [31:0]  word_next;

    assign rx_ready   = flags.rx_ready;
    assign busy       = flags.busy;
    assign done       = flags.done;
    assign error      = flags.error;
    assign core_reset = flags.core_reset;

    assign accept    = rx_valid && flags.rx_ready;
    assign can_start = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // Length as it will be once the high byte in flight is taken.
    assign len_full = {1'b0, rx_data, len[7:0]};
    assign len_bad  = (len_full == 17'd0) || (len_full > DEPTH_W);

    word_assembler u_word_assembler (
        .CLK       (CLK),
        .reset     (reset),
        .clear     (can_start),
        .byte_en   (accept && (state == S_DATA)),
        .byte_in   (rx_data),
        .word_next (word_next),
        .word_done (word_done)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            flags      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            err_code   <= ERR_NONE;
            len        <= 16'd0;
            word_cnt   <= 16'd0;
            csum       <= 8'd0;
        end else begin
            imem_we <= 1'b0;
            // Address advances right after each write pulse.
            if (imem_we) begin
                imem_addr <= imem_addr + AW'(1);
            end

            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_LEN_LO;
                        flags     <= flags_of(S_LEN_LO);
                        err_code  <= ERR_NONE;
                        word_cnt  <= 16'd0;
                        csum      <= 8'd0;
                        imem_addr <= '0;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= rx_data;
                        state    <= S_LEN_HI;
                        flags    <= flags_of(S_LEN_HI);
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= rx_data;
                        if (len_bad) begin
                            state    <= S_ERR;
                            flags    <= flags_of(S_ERR);
                            err_code <= ERR_LEN;
                        end else begin
                            state <= S_DATA;
                            flags <= flags_of(S_DATA);
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ rx_data;
                        if (word_done) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= word_next;
                            word_cnt   <= word_cnt + 16'd1;
                            if (word_cnt + 16'd1 == len) begin
                                state <= S_CSUM;
                                flags <= flags_of(S_CSUM);
                            end
                        end
                    end
                end

                S_CSUM: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state <= S_DONE;
                            flags <= flags_of(S_DONE);
                        end else begin
                            state    <= S_ERR;
                            flags    <= flags_of(S_ERR);
                            err_code <= ERR_CSUM;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    flags <= flags_of(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: stream-level reference model, a
// per-cycle compare process, an expected-write queue and directed plus
// randomized loads.
// ---------------------------------------------------------------------------
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    // ---------------- clock / reset ----------------
    logic          CLK;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    loader_state_t state;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .state      (state)
    );

    // ---------------- scoreboard state ----------------
    int n_compared   = 0;
    int n_mismatched = 0;
    logic [AW+31:0] exp_q[$];
    logic [7:0]     pay_q[$];
    int             wr_seen = 0;
    logic [AW-1:0]  last_waddr;
    logic [31:0]    last_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the stream by byte index: 0 = LEN_LO, 1 = LEN_HI, 2..4N+1 payload,
    // 4N+2 checksum. Produces what every output must be on each cycle.
    logic          m_loading, m_done, m_error, m_we;
    logic [1:0]    m_code;
    logic [7:0]    m_lo, m_xor;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    int            m_idx, m_n, m_len, m_p;
    logic [7:0]    m_bytes[4*DEPTH];

    assign m_len = int'({rx_data, m_lo});
    assign m_p   = m_idx - 2;

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_loading <= 1'b0;
            m_done    <= 1'b0;
            m_error   <= 1'b0;
            m_code    <= 2'b00;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= 32'd0;
            m_idx     <= 0;
            m_n       <= 0;
            m_lo      <= 8'd0;
            m_xor     <= 8'd0;
        end else begin
            m_we <= 1'b0;
            if (!m_loading) begin
                if (start) begin
                    m_loading <= 1'b1;
                    m_done    <= 1'b0;
                    m_error   <= 1'b0;
                    m_code    <= 2'b00;
                    m_idx     <= 0;
                    m_xor     <= 8'd0;
                end
            end else if (rx_valid) begin
                m_idx <= m_idx + 1;
                if (m_idx == 0) begin
                    m_lo <= rx_data;
                end else if (m_idx == 1) begin
                    if (m_len == 0 || m_len > DEPTH) begin
                        m_loading <= 1'b0;
                        m_error   <= 1'b1;
                        m_code    <= 2'b01;
                    end else begin
                        m_n <= m_len;
                    end
                end else if (m_p < 4 * m_n) begin
                    m_bytes[m_p] <= rx_data;
                    m_xor        <= m_xor ^ rx_data;
                    if (m_p % 4 == 3) begin
                        m_we    <= 1'b1;
                        m_addr  <= AW'(m_p / 4);
                        m_wdata <= {rx_data, m_bytes[m_p-1], m_bytes[m_p-2], m_bytes[m_p-3]};
                    end
                end else begin
                    m_loading <= 1'b0;
                    if (rx_data == m_xor) begin
                        m_done <= 1'b1;
                    end else begin
                        m_error <= 1'b1;
                        m_code  <= 2'b10;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        logic [AW+31:0] e;
        check("busy", busy, m_loading);
        check("rx_ready", rx_ready, m_loading);
        check("done", done, m_done);
        check("error", error, m_error);
        check("err_code", err_code, m_code);
        check("core_reset", core_reset, m_done);
        check("imem_we", imem_we, m_we);
        if (imem_we) begin
            wr_seen++;
            last_waddr = imem_addr;
            last_wdata = imem_wdata;
            check("wr_addr_model", imem_addr, m_addr);
            check("wr_data_model", imem_wdata, m_wdata);
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr_sb", imem_addr, e[AW+31:32]);
                check("wr_data_sb", imem_wdata, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < 4 * n; i++) pay_q.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Presents one byte (after optional random idle cycles) and returns on the
    // falling edge after it has been taken.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit with_start);
        int g;
        int t;
        g = 0;
        while (g < 6 && $urandom_range(0, 99) < gap_pct) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge CLK);
            g++;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        if (with_start) start = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 100) begin
            @(negedge CLK);
            start = 1'b0;
            t++;
        end
        check("byte_accept_wait", t < 100, 1);
        @(negedge CLK);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Full load of n words using pay_q as payload; checksum is the XOR of the
    // payload with 'flip' applied. Outcome is checked against what the stream
    // itself implies.
    task automatic run_load(input int n, input int gap_pct, input logic [7:0] flip, input int start_at);
        logic [7:0] stream[$];
        logic [7:0] x;
        bit         len_ok;
        bit         good;
        int         w0;
        int         t;
        len_ok = (n >= 1 && n <= DEPTH);
        good   = len_ok && (flip == 8'd0);
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        x = 8'd0;
        if (len_ok) begin
            for (int i = 0; i < 4 * n; i++) begin
                stream.push_back(pay_q[i]);
                x ^= pay_q[i];
            end
            for (int i = 0; i < n; i++)
                exp_q.push_back({AW'(i), pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]});
            stream.push_back(x ^ flip);
        end
        w0 = wr_seen;
        pulse_start();
        foreach (stream[i]) send_byte(stream[i], gap_pct, (i == start_at));
        t = 0;
        while (!(done || error) && t < 50) begin
            @(negedge CLK);
            t++;
        end
        check("outcome_wait", t < 50, 1);
        check("ld_done", done, good);
        check("ld_error", error, !good);
        check("ld_err_code", err_code, !len_ok ? 32'd1 : (flip != 8'd0 ? 32'd2 : 32'd0));
        check("ld_core_reset", core_reset, good);
        check("ld_writes", wr_seen - w0, len_ok ? n : 0);
        check("ld_exp_q_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_core_reset"}, core_reset, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_state"}, state, S_IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        int n;
        int sa;
        logic [7:0] flip;
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        reset = 1'b1;

        // Bytes offered while idle must be ignored.
        @(negedge CLK);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(negedge CLK);
        rx_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_writes", wr_seen, 0);

        // Directed single-word load: 01 00 13 05 A0 00, checksum B6.
        pay_q.delete();
        pay_q.push_back(8'h13);
        pay_q.push_back(8'h05);
        pay_q.push_back(8'hA0);
        pay_q.push_back(8'h00);
        run_load(1, 0, 8'h00, -1);
        check("t1_wdata", last_wdata, 32'h00A00513);
        check("t1_waddr", last_waddr, 0);
        check("t1_done", done, 1);
        check("t1_core_reset", core_reset, 1);

        // Start while in DONE: core goes back into reset on the next cycle.
        pulse_start();
        check("restart_core_reset", core_reset, 0);
        check("restart_busy", busy, 1);

        // Three words with random rx_valid gaps.
        fill_payload(3);
        run_load(3, 50, 8'h00, -1);
        check("t3_last_addr", last_waddr, 2);

        // Bad lengths: 0 and 1025.
        run_load(0, 0, 8'h00, -1);
        check("len0_err_code", err_code, 2'b01);
        run_load(1025, 0, 8'h00, -1);
        check("len1025_err_code", err_code, 2'b01);
        check("len1025_core_reset", core_reset, 0);

        // Checksum off by 01.
        fill_payload(1);
        run_load(1, 0, 8'h01, -1);
        check("csum_err_code", err_code, 2'b10);

        // Start during DATA is ignored.
        fill_payload(2);
        run_load(2, 20, 8'h00, 5);

        // Reset after six payload bytes of a two-word load.
        fill_payload(2);
        exp_q.push_back({AW'(0), pay_q[3], pay_q[2], pay_q[1], pay_q[0]});
        w0 = wr_seen;
        pulse_start();
        send_byte(8'd2, 0, 1'b0);
        send_byte(8'd0, 0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pay_q[i], 30, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        check("abort_writes", wr_seen - w0, 1);
        check("abort_exp_q_empty", exp_q.size(), 0);
        @(negedge CLK);
        reset = 1'b1;
        fill_payload(2);
        run_load(2, 20, 8'h00, -1);

        // Randomized loads, including occasional bad lengths and checksums.
        for (int r = 0; r < 12; r++) begin
            flip = 8'h00;
            sa   = -1;
            if (r % 5 == 4) begin
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 65535);
            end else begin
                n = $urandom_range(1, 8);
                fill_payload(n);
                if ($urandom_range(0, 3) == 0) flip = 8'($urandom_range(1, 255));
                if ($urandom_range(0, 2) == 0) sa = $urandom_range(2, 1 + 4 * n);
            end
            run_load(n, $urandom_range(0, 60), flip, sa);
        end

        // Largest legal image fills the whole IMEM.
        fill_payload(DEPTH);
        run_load(DEPTH, 0, 8'h00, -1);
        check("full_last_addr", last_waddr, DEPTH - 1);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the IMEM depth in 32-bit words.
REQ-002 The block SHALL have parameter AW, default 10, giving the word-address width (log2 DEPTH).
REQ-003 The block SHALL have port CLK, input, 1 bit: single clock; all state updates on posedge CLK.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 The block SHALL have port rx_data, input, 8 bits: incoming byte stream.
REQ-007 The block SHALL have port rx_valid, input, 1 bit: rx_data holds a valid byte.
REQ-008 The block SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port imem_we, output, 1 bit: IMEM write strobe.
REQ-010 The block SHALL have port imem_addr, output, AW bits: IMEM word address.
REQ-011 The block SHALL have port imem_wdata, output, 32 bits: IMEM write word.
REQ-012 The block SHALL have port core_reset, output, 1 bit: active-low reset to the core; low holds the core.
REQ-013 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 The block SHALL have ports done and error, output, 1 bit each, plus err_code, output, 2 bits: load outcome.

Function
REQ-015 The byte stream SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4N payload bytes, then one checksum byte.
REQ-016 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE and ERR.
REQ-017 A byte SHALL be accepted only on a cycle where rx_valid and rx_ready are both 1; rx_ready SHALL be 1 exactly in LEN_LO, LEN_HI, DATA and CSUM.
REQ-018 In IDLE, DONE or ERR, start=1 SHALL move the FSM to LEN_LO and clear done, error, err_code, the word index and the checksum on the next edge; start while busy SHALL be ignored.
REQ-019 On acceptance in LEN_HI, N=0 or N>DEPTH SHALL move the FSM to ERR with err_code=01; otherwise the FSM SHALL move to DATA.
REQ-020 Payload byte k (k=0..3) of each word SHALL land in imem_wdata[8k+7:8k].
REQ-021 imem_we SHALL pulse high for exactly one cycle, registered, on the cycle after the 4th byte of a word is accepted; imem_addr SHALL be the word index, starting at 0 and incrementing after each write.
REQ-022 After byte 4N is accepted the FSM SHALL enter CSUM; a CSUM acceptance in the same cycle as the final imem_we pulse is legal.
REQ-023 The checksum SHALL be the XOR of all 4N payload bytes; a match SHALL give DONE, and a mismatch SHALL give ERR with err_code=10.
REQ-024 busy SHALL be 1 in LEN_LO, LEN_HI, DATA and CSUM; done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-025 core_reset SHALL be 1 only in DONE and 0 in every other state.
REQ-026 rx_valid=1 in a state where rx_ready=0 SHALL have no effect; rx_valid gaps mid-word SHALL be tolerated without losing assembly position.
REQ-027 imem_we SHALL never assert outside DATA and the single cycle that follows it, and SHALL never assert with imem_addr >= N.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=0, busy=0, done=0, error=0 and err_code=00.
REQ-029 A reset during a load SHALL abort it; words already written remain in IMEM, and the core SHALL stay held until a later load reaches DONE.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the err_code constants (00 none, 01 bad length, 10 checksum) and the DEPTH default.
REQ-031 Word assembly, comprising the byte lane counter and shift register, SHALL be one sub-module, word_assembler; the FSM, counters and checksum SHALL live in imem_loader.

Verification
REQ-032 start, then bytes 01 00 13 05 A0 00 and checksum B6 -> one imem_we at addr 0 with wdata 00A00513, then done=1 and core_reset=1.
REQ-033 N=3 with a random rx_valid gap pattern -> writes at addr 0, 1, 2 with the correct words and no lost or duplicated bytes.
REQ-034 LEN bytes 00 00, and separately 01 04 (N=1025) -> error=1, err_code=01, no imem_we, core_reset=0.
REQ-035 N=1 payload with checksum off by 01 -> the write occurs, then error=1, err_code=10, core_reset=0.
REQ-036 reset pulled low after 6 payload bytes -> all outputs at reset values immediately; a new start with a full valid stream then reaches done.
REQ-037 start asserted during DATA -> ignored and the load completes normally; start in DONE -> core_reset returns to 0 the next cycle.
